extern_rr_arbiter: RTL

- Shares one fixed-latency external function unit among NREQ requesters: 16-bit operand in, 8-bit result out, same shape as the `mymod` extern.
- Round-robin grant; at most one issue per cycle.
- Tracks in-flight owner IDs so each result is returned to the requester that issued it.
- Sits between generated top-level datapaths and the single shared extern instance.

---
 rtl/extern_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 40 ++++
 rtl/extern_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/extern_arb_pkg.sv
// Shared types and default widths for the extern round-robin arbiter.
package extern_arb_pkg;

   localparam int unsigned IW_DEF  = 16;
   localparam int unsigned OW_DEF  = 8;
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned ID_W    = 3;

   typedef logic [ID_W-1:0] id_t;

   typedef struct packed {
      logic v;
      id_t  id;
   } inflight_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester after 'last', wrapping.
module rr_pick
   import extern_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] valid,
   input  id_t             last,
   output id_t             grant,
   output logic [NREQ-1:0] onehot,
   output logic            any
);

   logic [MAX_REQ-1:0] vpad;
   int unsigned        s;
   id_t                cand;

   always_comb begin
      vpad   = '0;
      grant  = '0;
      onehot = '0;
      any    = 1'b0;
      s      = 0;
      cand   = '0;
      vpad[NREQ-1:0] = valid;
      // last < NREQ always, so a single subtraction implements the modulo
      for (int unsigned k = 1; k <= NREQ; k++) begin
         s = 32'(last) + k;
         if (s >= NREQ) s = s - NREQ;
         cand = id_t'(s);
         if (!any && vpad[cand]) begin
            any   = 1'b1;
            grant = cand;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++)
         onehot[i] = any && (grant == id_t'(i));
   end

endmodule

// File: rtl/extern_rr_arbiter.sv
// Round-robin sharing of one fixed-latency extern unit, with in-flight owner tracking.
// Optional counters (grant_cnt, max_wait) enabled by EXTERN_RR_ARB_PERF_EN.
module extern_rr_arbiter
   import extern_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 1,
   parameter int unsigned IW   = IW_DEF,
   parameter int unsigned OW   = OW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ*IW-1:0] req_data,
   output logic [NREQ-1:0]  req_ready,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [OW-1:0]    rsp_data,
   output logic [IW-1:0]    ext_x,
   input  logic [OW-1:0]    ext_out,
   output logic             busy
`ifdef EXTERN_RR_ARB_PERF_EN
   ,
   output logic [NREQ*32-1:0] grant_cnt,
   output logic [15:0]        max_wait
`endif
);

   id_t             last_grant;
   id_t             grant;
   logic [NREQ-1:0] onehot;
   logic            any;
   logic            xfer;
   inflight_t       pipe [LAT];
   inflight_t       tail;
   logic            pipe_any;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid  (req_valid),
      .last   (last_grant),
      .grant  (grant),
      .onehot (onehot),
      .any    (any)
   );

   // Grant and operand mux; everything held quiet while rst is high
   always_comb begin
      xfer      = any & ~rst;
      req_ready = xfer ? onehot : '0;
      ext_x     = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         if (req_ready[i]) ext_x = req_data[i*IW +: IW];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_grant <= id_t'(NREQ - 1);
      else if (xfer) last_grant <= grant;
   end

   // Owner pipe: never stalls, so its tail lines up with ext_out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0].v  <= xfer;
         pipe[0].id <= grant;
         for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      tail      = pipe[LAT-1];
      pipe_any  = 1'b0;
      rsp_valid = '0;
      for (int unsigned i = 0; i < LAT; i++) pipe_any = pipe_any | pipe[i].v;
      for (int unsigned i = 0; i < NREQ; i++)
         rsp_valid[i] = tail.v && (tail.id == id_t'(i));
      rsp_data = tail.v ? ext_out : '0;
      busy     = ~rst & (pipe_any | (|req_valid));
   end

`ifdef EXTERN_RR_ARB_PERF_EN
   logic [15:0] wait_run [NREQ];
   logic [15:0] wait_nxt [NREQ];
   logic [15:0] run_max;

   // Per-requester stall run length, saturating at all-ones
   always_comb begin
      run_max = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         wait_nxt[i] = '0;
         if (req_valid[i] && !req_ready[i])
            wait_nxt[i] = (wait_run[i] == 16'hFFFF) ? 16'hFFFF : wait_run[i] + 16'd1;
         if (wait_nxt[i] > run_max) run_max = wait_nxt[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
         max_wait  <= '0;
         for (int unsigned i = 0; i < NREQ; i++) wait_run[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            wait_run[i] <= wait_nxt[i];
            if (req_ready[i]) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
         end
         if (run_max > max_wait) max_wait <= run_max;
      end
   end
`endif

endmodule
